// File: rtl/sar_search.sv
// sar_search: MSB-first successive-approximation search driving an external comparator's B operand.
module sar_search #(
   parameter int W      = 4,
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         cmp_E,
   input  logic         cmp_L,
   input  logic         cmp_G,
   output logic [W-1:0] trial,
   output logic         busy,
   output logic         done,
   output logic         found,
   output logic         err,
   output logic [W-1:0] result
);
   localparam int IW = $clog2(W);
   localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   typedef enum logic {IDLE, PROBE} state_t;
   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   trial_q, trial_d, result_q, result_d;
   logic           busy_q, busy_d, done_q, done_d, found_q, found_d, err_q, err_d;
   logic           valid;
   assign valid = $onehot({cmp_E, cmp_L, cmp_G});
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         trial_q  <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         found_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         trial_q  <= trial_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         found_q  <= found_d;
         err_q    <= err_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      trial_d  = trial_q;
      result_d = result_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      found_d  = found_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               trial_d        = '0;
               trial_d[W-1]   = 1'b1;
               idx_d          = IW'(W - 1);
               cnt_d          = CW'(SETTLE - 1);
               found_d        = 1'b0;
               err_d          = 1'b0;
               result_d       = '0;
               busy_d         = 1'b1;
               state_d        = PROBE;
            end
         end
         PROBE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (!valid || cmp_E || idx_q == '0) begin
               // every terminal outcome: inconsistent response, match, or last bit resolved
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
               err_d    = !valid || (!cmp_E && cmp_G);
               found_d  = valid && (cmp_E || cmp_L);
               result_d = !valid ? '0 : cmp_E ? trial_q : cmp_L ? {trial_q[W-1:1], 1'b0} : '0;
            end else begin
               trial_d[idx_q]          = cmp_G;
               trial_d[idx_q - IW'(1)] = 1'b1;
               idx_d                   = idx_q - IW'(1);
               cnt_d                   = CW'(SETTLE - 1);
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign trial  = trial_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign found  = found_q;
   assign err    = err_q;
   assign result = result_q;
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: two instances (SETTLE=1 and SETTLE=3) checked every cycle against a binary-search model.
module tb_sar_search;
   logic       clk = 1'b0;
   logic       rst;
   logic       start [2];
   logic       ce [2], cl [2], cg [2];
   logic [3:0] trial [2], result [2];
   logic       busy [2], done [2], found [2], err [2];
   int         tgt [2], flt [2];
   int         checks = 0, errors = 0;
   int         cyc = 0;
   bit         sv [2];
   int         s_cyc [2], k_m [2], r_m [2], t_m [2];
   bit         f_m [2], e_m [2];

   always #5 clk = ~clk;

   sar_search #(.W(4), .SETTLE(1)) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .cmp_E(ce[0]), .cmp_L(cl[0]), .cmp_G(cg[0]),
      .trial(trial[0]), .busy(busy[0]), .done(done[0]), .found(found[0]), .err(err[0]), .result(result[0]));
   sar_search #(.W(4), .SETTLE(3)) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .cmp_E(ce[1]), .cmp_L(cl[1]), .cmp_G(cg[1]),
      .trial(trial[1]), .busy(busy[1]), .done(done[1]), .found(found[1]), .err(err[1]), .result(result[1]));

   // comparator with A=target; f=1 silences all outputs, f=2 answers G when probing 0001
   function automatic logic [2:0] cmp(input int t, input logic [3:0] tr, input int f);
      if (f == 1) return 3'b000;
      if (f == 2 && tr == 4'd1) return 3'b001;
      return {t == int'(tr), t < int'(tr), t > int'(tr)};
   endfunction
   assign {ce[0], cl[0], cg[0]} = cmp(tgt[0], trial[0], flt[0]);
   assign {ce[1], cl[1], cg[1]} = cmp(tgt[1], trial[1], flt[1]);

   function automatic int st(input int d);
      return d == 0 ? 1 : 3;
   endfunction

   // j-th probe: target's top j bits followed by a single trial one
   function automatic int pv(input int t, input int j);
      return ((t >> (4 - j)) << (4 - j)) + (1 << (3 - j));
   endfunction

   task automatic mdl(input int t, input int f, output int k, output int r, output bit fd, output bit e);
      if (f == 1) begin
         k = 1; r = 0; fd = 0; e = 1;
      end else if (f == 2) begin
         k = 4; r = 0; fd = 0; e = 1;
      end else begin
         k = 4;
         for (int j = 3; j >= 0; j--) if (pv(t, j) == t) k = j + 1;
         r = t; fd = 1; e = 0;
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge rst) begin
      sv[0] = 0;
      sv[1] = 0;
   end

   always @(posedge clk) begin
      if (!rst) begin
         cyc++;
         for (int d = 0; d < 2; d++)
            if (start[d] && (!sv[d] || cyc - s_cyc[d] > k_m[d] * st(d))) begin
               sv[d] = 1;
               s_cyc[d] = cyc;
               t_m[d] = tgt[d];
               mdl(tgt[d], flt[d], k_m[d], r_m[d], f_m[d], e_m[d]);
            end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            int m, j, xt, xb, xd, xf, xe, xr;
            if (!sv[d]) begin
               xt = 0; xb = 0; xd = 0; xf = 0; xe = 0; xr = 0;
            end else begin
               m  = cyc - s_cyc[d];
               j  = m / st(d) < k_m[d] - 1 ? m / st(d) : k_m[d] - 1;
               xt = pv(t_m[d], j);
               xb = int'(m < k_m[d] * st(d));
               xd = int'(m == k_m[d] * st(d));
               xf = m >= k_m[d] * st(d) ? int'(f_m[d]) : 0;
               xe = m >= k_m[d] * st(d) ? int'(e_m[d]) : 0;
               xr = m >= k_m[d] * st(d) ? r_m[d] : 0;
            end
            chk($sformatf("dut%0d trial", d), int'(trial[d]), xt);
            chk($sformatf("dut%0d busy", d), int'(busy[d]), xb);
            chk($sformatf("dut%0d done", d), int'(done[d]), xd);
            chk($sformatf("dut%0d found", d), int'(found[d]), xf);
            chk($sformatf("dut%0d err", d), int'(err[d]), xe);
            chk($sformatf("dut%0d result", d), int'(result[d]), xr);
         end
      end
   end

   task automatic search(input int d, input int t, input int f, input int lat, input int res, input int e);
      int n;
      tgt[d] = t;
      flt[d] = f;
      @(negedge clk);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      n = 0;
      while (!done[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (lat >= 0) chk($sformatf("latency t=%0d", t), n, lat);
      else chk($sformatf("probes<=4 t=%0d", t), int'(n <= 4 * st(d)), 1);
      chk($sformatf("pin result t=%0d", t), int'(result[d]), res);
      chk($sformatf("pin err t=%0d", t), int'(err[d]), e);
      chk($sformatf("pin found t=%0d", t), int'(found[d]), 1 - e);
      flt[d] = 0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      start[0] = 1'b0; start[1] = 1'b0;
      tgt[0] = 0; tgt[1] = 0; flt[0] = 0; flt[1] = 0;
      repeat (2) @(negedge clk);
      chk("reset trial", int'(trial[0]), 0);
      chk("reset busy", int'(busy[0]), 0);
      chk("reset result", int'(result[1]), 0);
      #2 rst = 1'b0;
      search(0, 4'b0100, 0, 2, 4'b0100, 0);
      search(0, 4'b1101, 0, 4, 4'b1101, 0);
      search(0, 4'b0000, 0, 4, 4'b0000, 0);
      search(0, 4'b1111, 0, 4, 4'b1111, 0);
      for (int t = 0; t < 16; t++) search(0, t, 0, -1, t, 0);
      search(0, 4'b0101, 1, 1, 0, 1);
      search(0, 4'b0000, 2, 4, 0, 1);
      // asynchronous reset while the second probe is on the bus
      tgt[0] = 13;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      @(negedge clk);
      chk("pre-reset trial", int'(trial[0]), 4'b1100);
      #2 rst = 1'b1;
      #1;
      chk("async trial", int'(trial[0]), 0);
      chk("async busy", int'(busy[0]), 0);
      chk("async flags", int'({done[0], found[0], err[0]}), 0);
      chk("async result", int'(result[0]), 0);
      #1 rst = 1'b0;
      repeat (6) @(negedge clk);
      search(0, 4'b1101, 0, 4, 4'b1101, 0);
      // SETTLE=3 with ignored start pulses while busy, then a back-to-back start in the done cycle
      tgt[1] = 4'b0111;
      @(negedge clk);
      start[1] = 1'b1;
      @(negedge clk);
      n = 0;
      while (!done[1] && n < 100) begin
         start[1] = n == 3 || n == 7;
         @(negedge clk);
         n++;
      end
      chk("settle3 latency", n, 12);
      chk("settle3 result", int'(result[1]), 4'b0111);
      tgt[1] = 4'b0010;
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      chk("b2b cleared found", int'(found[1]), 0);
      n = 0;
      while (!done[1] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b latency", n, 9);
      chk("b2b result", int'(result[1]), 4'b0010);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
